instr_realign_buffer: RTL and testbench



---
 rtl/instr_realign_buffer_pkg.sv | 24 ++
 rtl/instr_realign_buffer_halfword_fifo.sv | 69 ++++++
 rtl/instr_realign_buffer.sv | 118 +++++++++++
 tb/tb_instr_realign_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_realign_buffer_pkg.sv
// rtl/instr_realign_buffer_pkg.sv - shared types, widths and decode helper for the realignment buffer
// Contents: FETCH_W/HW_W widths, fetch_word_type, if_id_type (IF/ID payload), is_compressed().
package instr_realign_buffer_pkg;

    localparam int FETCH_W = 32;
    localparam int HW_W    = 16;

    typedef struct packed {
        logic [FETCH_W-1:0] addr;
        logic [FETCH_W-1:0] data;
    } fetch_word_type;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        compflg;
    } if_id_type;

    // Any low-bit pattern other than 2'b11 marks a 16-bit instruction.
    function automatic logic is_compressed(input logic [HW_W-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_realign_buffer_halfword_fifo.sv
// rtl/instr_realign_buffer_halfword_fifo.sv - circular halfword queue, 0/1/2 push and 0/1/2 pop per cycle
// Ports: clk, reset (async, active-high), clear (sync discard), push_n/push_hw0/push_hw1 (write side),
//        pop_n (read side), count (occupancy), hw0/hw1 (head and next halfword).
module halfword_fifo
    import instr_realign_buffer_pkg::*;
#(
    parameter int DEPTH_HW = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [1:0]                push_n,
    input  logic [HW_W-1:0]           push_hw0,
    input  logic [HW_W-1:0]           push_hw1,
    input  logic [1:0]                pop_n,
    output logic [$clog2(DEPTH_HW):0] count,
    output logic [HW_W-1:0]           hw0,
    output logic [HW_W-1:0]           hw1
);

    localparam int AW = $clog2(DEPTH_HW);

    logic [HW_W-1:0] mem_q [DEPTH_HW];
    logic [HW_W-1:0] mem_d [DEPTH_HW];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_n != 2'd0) mem_d[wr_ptr_q] = push_hw0;
            // Pointer arithmetic is AW bits wide so the second slot wraps naturally.
            if (push_n == 2'd2) mem_d[wr_ptr_q + AW'(1)] = push_hw1;
            wr_ptr_d = wr_ptr_q + AW'(push_n);
            rd_ptr_d = rd_ptr_q + AW'(pop_n);
            count_d  = count_q + (AW+1)'(push_n) - (AW+1)'(pop_n);
        end
    end

    // Storage needs no reset: count gates every use of its contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign hw0   = mem_q[rd_ptr_q];
    assign hw1   = mem_q[rd_ptr_q + AW'(1)];

endmodule

// File: rtl/instr_realign_buffer.sv
// rtl/instr_realign_buffer.sv - fetch-side halfword realignment buffer feeding the IF/ID register
// Macro: C_EXT_EN enables compressed decode and halfword-aligned PCs; undefined = 32-bit only.
// Ports: clk, reset (async, active-high), flush/flush_pc (redirect),
//        fetch_addr/fetch_valid/fetch_ready/fetch_data (word-aligned fetch side),
//        out_valid/out_ready/out (one if_id_type instruction per cycle).
module instr_realign_buffer
    import instr_realign_buffer_pkg::*;
#(
    parameter int          DEPTH_HW = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [31:0]  flush_pc,
    output logic [31:0]  fetch_addr,
    input  logic         fetch_valid,
    output logic         fetch_ready,
    input  logic [31:0]  fetch_data,
    output logic         out_valid,
    input  logic         out_ready,
    output if_id_type    out
);

    localparam int CW = $clog2(DEPTH_HW) + 1;

`ifdef C_EXT_EN
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif

    localparam logic [31:0] RESET_PC_EFF = RESET_PC & PC_MASK;

    logic [CW-1:0]   count;
    logic [HW_W-1:0] hw0, hw1;
    logic            head_comp;
    logic            push, pop;
    logic [1:0]      push_n, pop_n;
    logic [HW_W-1:0] push_hw0;
    logic [31:0]     flush_pc_eff;

    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        skip_lo_q, skip_lo_d;

`ifdef C_EXT_EN
    assign head_comp = is_compressed(hw0);
`else
    assign head_comp = 1'b0;
`endif

    assign flush_pc_eff = flush_pc & PC_MASK;
    assign out_valid    = ((count >= CW'(1)) && head_comp) || ((count >= CW'(2)) && !head_comp);
    // Worst case push is two halfwords, so leave room for both.
    assign fetch_ready  = count <= CW'(DEPTH_HW - 2);
    assign push         = fetch_valid && fetch_ready && !flush;
    assign pop          = out_valid && out_ready && !flush;
    assign push_n       = push ? (skip_lo_q ? 2'd1 : 2'd2) : 2'd0;
    assign push_hw0     = skip_lo_q ? fetch_data[31:16] : fetch_data[15:0];
    assign pop_n        = pop ? (head_comp ? 2'd1 : 2'd2) : 2'd0;
    assign fetch_addr   = fetch_addr_q;

    halfword_fifo #(
        .DEPTH_HW (DEPTH_HW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push_n   (push_n),
        .push_hw0 (push_hw0),
        .push_hw1 (fetch_data[31:16]),
        .pop_n    (pop_n),
        .count    (count),
        .hw0      (hw0),
        .hw1      (hw1)
    );

    always_comb begin
        out_pc_d     = out_pc_q;
        fetch_addr_d = fetch_addr_q;
        skip_lo_d    = skip_lo_q;
        if (flush) begin
            out_pc_d     = flush_pc_eff;
            fetch_addr_d = flush_pc_eff & 32'hFFFF_FFFC;
            // A target in the upper half of a word drops that word's low half.
            skip_lo_d    = flush_pc_eff[1];
        end else begin
            if (push) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
                skip_lo_d    = 1'b0;
            end
            if (pop) out_pc_d = out_pc_q + (head_comp ? 32'd2 : 32'd4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_pc_q     <= RESET_PC_EFF;
            fetch_addr_q <= RESET_PC_EFF & 32'hFFFF_FFFC;
            skip_lo_q    <= RESET_PC_EFF[1];
        end else begin
            out_pc_q     <= out_pc_d;
            fetch_addr_q <= fetch_addr_d;
            skip_lo_q    <= skip_lo_d;
        end
    end

    always_comb begin
        out = '0;
        if (count != '0) begin
            out.pc          = out_pc_q;
            out.compflg     = head_comp;
            out.instruction = head_comp ? {16'h0000, hw0} : {hw1, hw0};
        end
    end

endmodule

// File: tb/tb_instr_realign_buffer.sv
// tb/tb_instr_realign_buffer.sv - scoreboard bench for instr_realign_buffer
module tb_instr_realign_buffer;
    import instr_realign_buffer_pkg::*;

    localparam int          DEPTH_HW = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef C_EXT_EN
    localparam bit CEXT = 1'b1;
`else
    localparam bit CEXT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, fetch_valid, out_ready;
    logic [31:0] flush_pc, fetch_data, fetch_addr;
    logic        fetch_ready, out_valid;
    if_id_type   out;

    always #5 clk = ~clk;

    instr_realign_buffer #(
        .DEPTH_HW (DEPTH_HW),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        comp;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    int          n_acc = 0;
    exp_t        exp_q[$];
    exp_t        e;
    logic [15:0] hwq[$];
    logic [31:0] mpc, maddr;
    logic        mskip;

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic comp);
        exp_t r;
        r.pc = pc;
        r.instr = instr;
        r.comp = comp;
        return r;
    endfunction

    task automatic model_restart(input logic [31:0] p);
        hwq.delete();
        exp_q.delete();
        mpc   = CEXT ? {p[31:1], 1'b0} : {p[31:2], 2'b00};
        maddr = {p[31:2], 2'b00};
        mskip = CEXT && p[1];
    endtask

    task automatic model_push(input logic [31:0] d);
        logic [15:0] h0, h1;
        if (!mskip) hwq.push_back(d[15:0]);
        hwq.push_back(d[31:16]);
        mskip = 1'b0;
        maddr = maddr + 32'd4;
        while (hwq.size() > 0) begin
            h0 = hwq[0];
            if (CEXT && h0[1:0] != 2'b11) begin
                exp_q.push_back(mk(mpc, {16'h0000, h0}, 1'b1));
                void'(hwq.pop_front());
                mpc = mpc + 32'd2;
            end else if (hwq.size() >= 2) begin
                h1 = hwq[1];
                exp_q.push_back(mk(mpc, {h1, h0}, 1'b0));
                void'(hwq.pop_front());
                void'(hwq.pop_front());
                mpc = mpc + 32'd4;
            end else begin
                break;
            end
        end
    endtask

    // Scoreboard: inputs are stable here (driven 1ns after posedge).
    always @(negedge clk) begin
        if (reset) begin
            model_restart(RESET_PC);
        end else if (flush) begin
            model_restart(flush_pc);
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected got pc=%h instr=%h required=no output", out.pc, out.instruction);
                end else begin
                    e = exp_q.pop_front();
                    if (out.pc !== e.pc || out.instruction !== e.instr || out.compflg !== e.comp) begin
                        bad++;
                        $display("FAIL sb_out got pc=%h instr=%h comp=%b required pc=%h instr=%h comp=%b",
                                 out.pc, out.instruction, out.compflg, e.pc, e.instr, e.comp);
                    end
                end
            end
            if (fetch_valid && fetch_ready) begin
                total++;
                if (fetch_addr !== maddr) begin
                    bad++;
                    $display("FAIL sb_fetch_addr got=%h required=%h", fetch_addr, maddr);
                end
                model_push(fetch_data);
                n_acc++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        fetch_valid = 1'b0;
        out_ready   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            cyc();
        end
        total++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain got pending=%0d out_valid=%b required pending=0 out_valid=0",
                     name, exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; flush_pc = '0;
        fetch_valid = 1'b0; fetch_data = '0; out_ready = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL reset_fetch_ready got=%b required=1", fetch_ready); end
        total++; if (fetch_addr !== {RESET_PC[31:2], 2'b00}) begin bad++; $display("FAIL reset_fetch_addr got=%h required=%h", fetch_addr, {RESET_PC[31:2], 2'b00}); end
        total++; if (out !== '0) begin bad++; $display("FAIL reset_out got=%h required=0", out); end
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_addi();
        do_reset();
        out_ready = 1'b0;
        fetch_valid = 1'b1; fetch_data = 32'h0041_0113;
        cyc();
        fetch_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b required=1", out_valid); end
        total++; if (out.pc !== 32'h0) begin bad++; $display("FAIL addi_pc got=%h required=0", out.pc); end
        total++; if (out.instruction !== 32'h0041_0113) begin bad++; $display("FAIL addi_instr got=%h required=00410113", out.instruction); end
        total++; if (out.compflg !== 1'b0) begin bad++; $display("FAIL addi_comp got=%b required=0", out.compflg); end
        drain("addi");
    endtask

    task automatic test_compressed();
        logic [31:0] want_i;
        logic        want_c;
        want_i = CEXT ? 32'h0000_4501 : 32'h0001_4501;
        want_c = CEXT;
        do_reset();
        out_ready = 1'b0;
        fetch_valid = 1'b1; fetch_data = 32'h0001_4501;
        cyc();
        fetch_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out.pc !== 32'h0) begin bad++; $display("FAIL comp_head got valid=%b pc=%h required valid=1 pc=0", out_valid, out.pc); end
        total++; if (out.instruction !== want_i || out.compflg !== want_c) begin bad++; $display("FAIL comp_instr got=%h/%b required=%h/%b", out.instruction, out.compflg, want_i, want_c); end
        drain("comp");
    endtask

    task automatic test_straddle();
        do_reset();
        out_ready = 1'b0;
        fetch_valid = 1'b1; fetch_data = 32'h0113_4501;
        cyc();
        fetch_valid = 1'b0;
`ifdef C_EXT_EN
        total++; if (out_valid !== 1'b1 || out.instruction !== 32'h0000_4501) begin bad++; $display("FAIL strad_first got valid=%b instr=%h required valid=1 instr=00004501", out_valid, out.instruction); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || out.pc !== 32'h2) begin bad++; $display("FAIL strad_hold got valid=%b pc=%h required valid=0 pc=2", out_valid, out.pc); end
        fetch_valid = 1'b1; fetch_data = 32'h5a5a_0041;
        cyc();
        fetch_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out.pc !== 32'h2 || out.instruction !== 32'h0041_0113 || out.compflg !== 1'b0) begin
            bad++; $display("FAIL strad_join got valid=%b pc=%h instr=%h required valid=1 pc=2 instr=00410113", out_valid, out.pc, out.instruction);
        end
`else
        total++; if (out_valid !== 1'b1 || out.instruction !== 32'h0113_4501) begin bad++; $display("FAIL strad_first got valid=%b instr=%h required valid=1 instr=01134501", out_valid, out.instruction); end
        fetch_valid = 1'b1; fetch_data = 32'h5a5a_0041;
        cyc();
        fetch_valid = 1'b0;
`endif
        drain("strad");
    endtask

    task automatic test_flush();
        logic [31:0] want_pc, want_i;
        want_pc = CEXT ? 32'h0000_0102 : 32'h0000_0100;
        want_i  = CEXT ? 32'h0000_4505 : 32'h4505_dead;
        out_ready = 1'b0;
        flush = 1'b1; flush_pc = 32'h0000_0102;
        fetch_valid = 1'b1; fetch_data = 32'hffff_ffff;
        cyc();
        flush = 1'b0;
        total++; if (fetch_addr !== 32'h100) begin bad++; $display("FAIL flush_addr got=%h required=00000100", fetch_addr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b required=0", out_valid); end
        fetch_data = 32'h4505_dead;
        cyc();
        fetch_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out.pc !== want_pc || out.instruction !== want_i) begin
            bad++; $display("FAIL flush_first got valid=%b pc=%h instr=%h required valid=1 pc=%h instr=%h", out_valid, out.pc, out.instruction, want_pc, want_i);
        end
        drain("flush");
    endtask

    task automatic test_backpressure();
        int        acc0;
        if_id_type snap;
        do_reset();
        out_ready = 1'b0;
        acc0 = n_acc;
        fetch_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fetch_data = 32'h0000_0013 | ((n_acc - acc0 + 1) << 7) | ((n_acc - acc0) << 20);
            cyc();
            if (i == 0) snap = out;
        end
        total++; if (n_acc - acc0 != 4) begin bad++; $display("FAIL bp_accepts got=%0d required=4", n_acc - acc0); end
        total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b required=0", fetch_ready); end
        total++; if (out !== snap || out_valid !== 1'b1) begin bad++; $display("FAIL bp_stable got=%h valid=%b required=%h valid=1", out, out_valid, snap); end
        drain("bp");
    endtask

    task automatic test_back_to_back();
        int acc0;
        do_reset();
        out_ready = 1'b1;
        acc0 = n_acc;
        fetch_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fetch_data = 32'h0000_0093 | (i << 20) | ((i & 31) << 15);
            cyc();
        end
        total++; if (n_acc - acc0 != 10) begin bad++; $display("FAIL b2b_accepts got=%0d required=10", n_acc - acc0); end
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        fetch_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_data = 32'h0000_0013 | (i << 7);
            cyc();
        end
        fetch_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || fetch_ready !== 1'b1) begin bad++; $display("FAIL mid_pre got valid=%b ready=%b required 1/1", out_valid, fetch_ready); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b required=0", out_valid); end
        total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b required=1", fetch_ready); end
        total++; if (fetch_addr !== {RESET_PC[31:2], 2'b00}) begin bad++; $display("FAIL mid_addr got=%h required=%h", fetch_addr, {RESET_PC[31:2], 2'b00}); end
        total++; if (out !== '0) begin bad++; $display("FAIL mid_out got=%h required=0", out); end
        cyc();
        reset = 1'b0;
        fetch_valid = 1'b1; fetch_data = 32'h0041_0113;
        cyc();
        drain("mid");
    endtask

    initial begin
        test_reset();
        test_addi();
        test_compressed();
        test_straddle();
        test_flush();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
